// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM-stage data-memory access controller: strobes accesses,
//               stalls the pipeline on wait states, holds read data, flags
//               illegal requests. Optional BUSY timeout via MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        flush_in,
    input  logic        mem_done,
    input  logic [15:0] mem_data_in,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] read_data_out,
    output logic        pipe_stall,
    output logic        mwb_bubble,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_hold;

    logic w_acc;
    logic w_illegal;
    logic w_legal;
    logic w_done_acc;
    logic w_timeout;
    logic w_en;
    logic w_wr;
    logic w_stall;
    logic w_bubble;

    assign w_acc     = (mem_read_in | mem_write_in) & ~flush_in;
    assign w_illegal = w_acc & mem_read_in & mem_write_in;
    assign w_legal   = w_acc & ~w_illegal;

    // mem_done only counts when an access is actually outstanding or issued now
    assign w_done_acc = mem_done & (((r_state == S_IDLE) & w_legal) | (r_state == S_BUSY));

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] c_timeout = 4'(TIMEOUT_CYCLES);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= 4'd0;
        end else if ((r_state == S_BUSY) && (r_cnt != 4'hF)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign w_timeout = (r_state == S_BUSY) && (r_cnt == c_timeout);
`else
    logic [3:0] w_unused_timeout;
    assign w_unused_timeout = 4'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hold  <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_done_acc) begin
                r_hold <= mem_data_in;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_en     = 1'b0;
        w_wr     = 1'b0;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_illegal) begin
                    // freeze the offending instruction while entering ERR
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    w_next   = S_ERR;
                end else if (w_legal) begin
                    w_en = 1'b1;
                    w_wr = mem_write_in;
                    if (!mem_done) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                        w_next   = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (mem_done) begin
                    w_next = S_IDLE;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (w_timeout) begin
                        w_next = S_ERR;
                    end
                end
            end
            S_ERR: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Every output is held low while reset is asserted
    assign mem_en        = ~rst & w_en;
    assign mem_wr        = ~rst & w_wr;
    assign pipe_stall    = ~rst & w_stall;
    assign mwb_bubble    = ~rst & w_bubble;
    assign busy          = ~rst & (r_state == S_BUSY);
    assign err           = ~rst & (r_state == S_ERR);
    assign read_data_out = rst        ? 16'h0000    :
                           w_done_acc ? mem_data_in : r_hold;

endmodule

`default_nettype wire
